// File: rtl/sha512_digest_out_pkg.sv
// Shared types and constants for the SHA-512 digest output stage.
// Build option: SHA384_TRUNC_EN selects the 6-word SHA-384 digest stream.
package sha512_digest_out_pkg;

    localparam int WORD_W = 64;
    localparam int PAIR_W = 2 * WORD_W;
    localparam int HASH_W = 8 * WORD_W;

`ifdef SHA384_TRUNC_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd7;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] hi;
        logic [WORD_W-1:0] lo;
    } pair_t;

    localparam logic [HASH_W-1:0] SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [HASH_W-1:0] SHA384_IV = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    function automatic pair_t pair_unpack(input logic [PAIR_W-1:0] p);
        pair_t r;
        r.hi = p[PAIR_W-1:WORD_W];
        r.lo = p[WORD_W-1:0];
        return r;
    endfunction

    // H0 lives in the top 64 bits, H7 in the bottom 64 bits.
    function automatic logic [WORD_W-1:0] hash_word(input logic [HASH_W-1:0] h, input logic [2:0] i);
        logic [8:0] base;
        base = {3'd7 - i, 6'd0};
        return h[base +: WORD_W];
    endfunction

endpackage

// File: rtl/sha512_digest_out_if.sv
// Handshake/data bundle between the round datapath, the digest output stage
// and the accelerator output port.
interface sha512_digest_out_if;
    import sha512_digest_out_pkg::*;

    logic              start;
    logic [HASH_W-1:0] work_in;
    logic [HASH_W-1:0] hash_in;
    logic [HASH_W-1:0] hash_out;
    logic              hash_wb;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, work_in, hash_in, dout_ready,
        input  hash_out, hash_wb, dout, dout_valid, busy, done
    );

    modport slave (
        input  start, work_in, hash_in, dout_ready,
        output hash_out, hash_wb, dout, dout_valid, busy, done
    );
endinterface

// File: rtl/sha512_pair_add.sv
// Lane-wise mod 2^64 add of two packed 128-bit pairs; carries never cross lanes.
module sha512_pair_add
    import sha512_digest_out_pkg::*;
(
    input  logic [PAIR_W-1:0] a,
    input  logic [PAIR_W-1:0] b,
    output logic [PAIR_W-1:0] sum
);
    pair_t a_s;
    pair_t b_s;
    logic [WORD_W-1:0] hi_s;
    logic [WORD_W-1:0] lo_s;

    assign a_s  = pair_unpack(a);
    assign b_s  = pair_unpack(b);
    // Each sum is truncated to 64 bits so the carry out of bit 63 is dropped.
    assign hi_s = a_s.hi + b_s.hi;
    assign lo_s = a_s.lo + b_s.lo;
    assign sum  = {hi_s, lo_s};
endmodule

// File: rtl/sha512_digest_out.sv
// SHA-512 finalization: feed-forward add into the chaining hash, then stream
// the digest words over valid/ready. SHA384_TRUNC_EN streams only H0..H5.
module sha512_digest_out #(
    parameter int WORD_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    sha512_digest_out_if.slave    bus
);
    import sha512_digest_out_pkg::*;

    if (WORD_W != 64) begin : g_word_w_check
        $error("sha512_digest_out: only WORD_W = 64 is supported");
    end

    state_e            state_r;
    state_e            state_s;
    logic [2:0]        idx_r;
    logic [2:0]        idx_s;
    logic [HASH_W-1:0] work_r;
    logic [HASH_W-1:0] hash_in_r;
    logic [HASH_W-1:0] hash_out_r;
    logic [HASH_W-1:0] sum_s;
    logic [63:0]       dout_r;
    logic [63:0]       dout_s;
    logic              hash_wb_r;
    logic              dout_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              accept_s;

    for (genvar p = 0; p < 4; p++) begin : g_pair
        sha512_pair_add u_pair_add (
            .a   (hash_in_r[HASH_W-1-p*PAIR_W -: PAIR_W]),
            .b   (work_r[HASH_W-1-p*PAIR_W -: PAIR_W]),
            .sum (sum_s[HASH_W-1-p*PAIR_W -: PAIR_W])
        );
    end

    assign accept_s = dout_valid_r & bus.dout_ready;

    // Next-state, word index and next digest word.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        dout_s  = dout_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                state_s = STREAM;
                idx_s   = 3'd0;
                dout_s  = hash_word(sum_s, 3'd0);
            end
            STREAM: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = FIN;
                    end else begin
                        idx_s  = idx_r + 3'd1;
                        dout_s = hash_word(hash_out_r, idx_r + 3'd1);
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                idx_s   = 3'd0;
            end
        endcase
    end

    // State, index and digest word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            dout_r  <= 64'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            dout_r  <= dout_s;
        end
    end

    // Operand capture on start and chaining-hash writeback in ADD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_r     <= '0;
            hash_in_r  <= '0;
            hash_out_r <= '0;
        end else begin
            if (state_r == IDLE && bus.start) begin
                work_r    <= bus.work_in;
                hash_in_r <= bus.hash_in;
            end
            if (state_r == ADD) begin
                hash_out_r <= sum_s;
            end
        end
    end

    // Status flags, registered from the upcoming state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hash_wb_r    <= 1'b0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            hash_wb_r    <= (state_r == ADD);
            dout_valid_r <= (state_s == STREAM);
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_s == FIN);
        end
    end

    assign bus.hash_out   = hash_out_r;
    assign bus.hash_wb    = hash_wb_r;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

endmodule

// File: doc/sha512_digest_out.md
# sha512_digest_out

Final-stage reader for the SHA-512 working-variable datapath. When a block's 80 rounds finish, it takes the packed working variables and the packed chaining hash. It performs the per-lane feed-forward add H_i + var_i mod 2^64, writes the updated chaining hash back, and streams the digest out as 64-bit words over a valid/ready handshake. It sits between the round datapath (producer of packed pairs) and the accelerator's output interface.

## Interface
Parameters:
- WORD_W, 64, lane width. The pair width is 2*WORD_W. Only 64 is supported; other values are a synthesis error.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to finalize; sampled only in IDLE
- work_in  in  512  packed pairs {ab, cd, ef, gh}; ab at [511:384]; in each pair the first variable is at [127:64] and the second at [63:0]
- hash_in  in  512  packed chaining hash {H0H1, H2H3, H4H5, H6H7}, same packing
- hash_out  out  512  registered updated chaining hash, same packing
- hash_wb  out  1  one-cycle pulse: hash_out has just been updated
- dout  out  64  digest word
- dout_valid  out  1  dout is valid
- dout_ready  in  1  consumer accepts dout
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- FSM states: IDLE, ADD, STREAM, FIN.
- IDLE, start=1: capture work_in and hash_in into internal registers, then go to ADD.
- ADD (exactly 1 cycle):
  - Eight independent 64-bit adds; each carry out of bit 63 is discarded and never propagates into the adjacent lane of the pair.
  - Results register into hash_out; hash_wb pulses; word index cleared to 0; go to STREAM.
- STREAM:
  - dout = H[idx] taken from hash_out, with H0 = hash_out[511:448], H1 = [447:384], …, H7 = [63:0]; dout_valid=1.
  - On dout_valid & dout_ready, idx increments.
  - On acceptance of the last word (idx = LAST), go to FIN.
- FIN (1 cycle): done=1, dout_valid=0; go to IDLE.
- start is ignored while busy=1; no queueing.
- hash_out holds its value in IDLE until the next ADD.
- Reset values: state IDLE, idx 0, hash_out 0, dout 0, dout_valid 0, hash_wb 0, done 0, busy 0.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. No partial writeback is retained.

## Timing
- start at cycle T (in IDLE) → ADD at T+1 → hash_wb=1 and new hash_out visible at T+2. First dout_valid=1 also at T+2.
- With dout_ready held high, one word per cycle: words at T+2 … T+2+LAST. done pulses the cycle after the last accept, and busy falls in the same cycle done falls.
- Minimum start-to-start spacing with ready held high: LAST+4 cycles.
- Backpressure: while dout_valid=1 and dout_ready=0, dout and idx hold stable. dout_valid never drops before acceptance.
- dout is driven from a registered index and a registered hash; there is no combinational path from dout_ready to dout.
- dout_valid is a registered state decode. dout_ready affects only next-state and idx.

## Configuration
- SHA384_TRUNC_EN defined: LAST = 5. Only H0..H5 are streamed (384-bit SHA-384 digest). hash_out is still fully updated (all eight lanes).
- SHA384_TRUNC_EN undefined: LAST = 7. All eight words are streamed.

## Structure
- The shared package holds:
  - state enum (IDLE, ADD, STREAM, FIN)
  - WORD_W and PAIR_W constants
  - SHA-512 and SHA-384 IV constants, used by the bench and by the chaining-hash init logic
  - a pair-unpack function returning {hi, lo} 64-bit lanes
- One sub-module: sha512_pair_add. It takes two 128-bit packed pairs and returns their lane-wise sum with no cross-lane carry. It is instantiated four times.

## Test plan
- work_in=0, hash_in=SHA-512 IV, ready=1 → hash_wb at T+2; words 6a09e667f3bcc908, bb67ae8584caa73b, … 5be0cd19137e2179 on consecutive cycles; done at T+10.
- Lane wrap: hash_in H0=H1=ffffffffffffffff, work a=b=1 → H0=H1=0. Also check hash_out[383:256] is unaffected (no carry between lanes or pairs).
- Backpressure: drop dout_ready for 5 cycles while word 3 is presented → dout/dout_valid stable; sequence resumes with word 3, no loss or duplicate.
- start pulsed at STREAM idx=2 → ignored; stream continues unchanged, exactly one done.
- reset asserted at idx=4 → next edge-independent: dout_valid=0, busy=0, hash_out=0; a subsequent start completes normally.
- SHA384_TRUNC_EN build, SHA-384 IV with zero work → exactly 6 words (cbbb9d5dc1059ed8 first), done after word 5, hash_out lanes 6–7 equal IV.
